// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult_ctrl
//  Brief    : Iterative shift-add multiplier sequencer for MULT/MULTU.
//             Runs WIDTH add/shift cycles, then loads the 2*WIDTH-bit
//             product into HI/LO with a one-cycle product-valid pulse.
//             Exposes busy/stallhilo for the hazard unit.
//  Revision : 1.0  initial release
// ============================================================================
module mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active low
  input  logic             multstartE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hiloreadE,
  output logic             busy,
  output logic             pve,
  output logic             stallhilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    c_IDLE = 2'd0,
    c_RUN  = 2'd1,
    c_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_neg;
  logic [2*WIDTH:0]     r_acc;     // extra top bit holds the add carry
  logic [CNT_W-1:0]     r_cnt;

  logic [WIDTH-1:0]     w_absA;
  logic [WIDTH-1:0]     w_absB;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH:0]     w_accAdd;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_result;

  // Magnitudes of the signed operands; the most negative value maps onto
  // itself, which is the correct magnitude when read as unsigned.
  always_comb begin
    w_absA = srcaE[WIDTH-1] ? -srcaE : srcaE;
    w_absB = srcbE[WIDTH-1] ? -srcbE : srcbE;
  end

  // One add/shift step: conditionally add the multiplicand into the upper half.
  always_comb begin
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    w_accAdd = r_mplier[0] ? {w_sum, r_acc[WIDTH-1:0]} : r_acc;
    w_prod   = r_acc[2*WIDTH-1:0];
    w_result = r_neg ? -w_prod : w_prod;
  end

  // Hazard outputs are combinational so the stall applies in the start cycle.
  assign busy      = multstartE | (r_state != c_IDLE);
  assign stallhilo = hiloreadE & busy;

  // Sequencer: latch operands, iterate WIDTH times, then write HI/LO and pulse pve.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      hi       <= '0;
      lo       <= '0;
      pve      <= 1'b0;
    end else begin
      pve <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (multstartE) begin
            if (signedE) begin
              r_mcand  <= w_absA;
              r_mplier <= w_absB;
              r_neg    <= srcaE[WIDTH-1] ^ srcbE[WIDTH-1];
            end else begin
              r_mcand  <= srcaE;
              r_mplier <= srcbE;
              r_neg    <= 1'b0;
            end
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          r_acc    <= w_accAdd >> 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == c_LAST) begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          hi      <= w_result[2*WIDTH-1:WIDTH];
          lo      <= w_result[WIDTH-1:0];
          pve     <= 1'b1;
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_ctrl
//  Brief    : Self-checking bench for mult_ctrl; expected products come from
//             plain 64-bit arithmetic on the operands.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         multstartE = 1'b0;
  logic         signedE = 1'b0;
  logic [W-1:0] srcaE = '0;
  logic [W-1:0] srcbE = '0;
  logic         hiloreadE = 1'b0;
  logic         busy;
  logic         pve;
  logic         stallhilo;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           nChecks = 0;
  int           nPass = 0;
  logic [W-1:0] expHi = '0;
  logic [W-1:0] expLo = '0;

  mult_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .multstartE (multstartE),
    .signedE    (signedE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .hiloreadE  (hiloreadE),
    .busy       (busy),
    .pve        (pve),
    .stallhilo  (stallhilo),
    .hi         (hi),
    .lo         (lo)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference product using native 64-bit arithmetic.
  function automatic logic [63:0] refProd(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    longint pa;
    longint pb;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // One full operation; optional ignored restart and random HI/LO reads while busy.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit glitch, input bit rdRun);
    logic [63:0] p;
    bit          seen;
    p = refProd(a, b, s);
    @(negedge clk);
    multstartE = 1'b1; srcaE = a; srcbE = b; signedE = s; hiloreadE = rdRun;
    #1;
    checkVal("busyStart", busy, 1);
    checkVal("stallStart", stallhilo, rdRun);
    seen = 0;
    // At negedge k, edges 0..k-1 have elapsed; results are due after edge W+1.
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      multstartE = glitch && (k == 5);
      srcaE      = $urandom;
      srcbE      = $urandom;
      signedE    = 1'($urandom_range(0, 1));
      hiloreadE  = rdRun ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (pve) begin
        seen = 1;
        checkVal("pveEdge", 64'(k - 1), 64'(W + 1));
        checkVal("hi", hi, p[63:32]);
        checkVal("lo", lo, p[31:0]);
      end else begin
        checkVal("busyRun", busy, 1);
        checkVal("stallRun", stallhilo, hiloreadE);
        checkVal("hiHold", hi, expHi);
        checkVal("loHold", lo, expLo);
      end
    end
    if (!seen) checkVal("pveTimeout", 0, 1);
    expHi = p[63:32];
    expLo = p[31:0];
    @(negedge clk);
    multstartE = 1'b0; hiloreadE = 1'b1;
    #1;
    checkVal("pveLow", pve, 0);
    checkVal("busyIdle", busy, 0);
    checkVal("stallIdle", stallhilo, 0);
    checkVal("hiAfter", hi, expHi);
    checkVal("loAfter", lo, expLo);
    hiloreadE = 1'b0;
  endtask

  // Start an op, reset at cycle 10, then confirm no result ever appears.
  task automatic resetAbort();
    int pveCount;
    @(negedge clk);
    multstartE = 1'b1; srcaE = 32'd1234; srcbE = 32'd5678; signedE = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      multstartE = 1'b0;
    end
    reset = 1'b0;
    #1;
    checkVal("abortHi", hi, 0);
    checkVal("abortLo", lo, 0);
    checkVal("abortBusy", busy, 0);
    checkVal("abortPve", pve, 0);
    @(negedge clk);
    reset = 1'b1;
    expHi = '0;
    expLo = '0;
    pveCount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (pve) pveCount++;
    end
    checkVal("abortNoPve", 64'(pveCount), 0);
    checkVal("abortBusyLater", busy, 0);
    checkVal("abortHiLater", hi, 0);
  endtask

  initial begin
    #1;
    checkVal("rstHi", hi, 0);
    checkVal("rstLo", lo, 0);
    checkVal("rstPve", pve, 0);
    checkVal("rstBusy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    runOp(32'd3, 32'd5, 1'b0, 0, 0);
    runOp(32'hFFFF_FFFF, 32'd2, 1'b1, 0, 1);
    runOp(32'hFFFF_FFFF, 32'd2, 1'b0, 0, 0);
    runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1);
    runOp(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0);
    runOp(32'h8000_0000, 32'd1, 1'b1, 0, 0);
    runOp(32'd0, 32'h1234_5678, 1'b1, 0, 0);

    resetAbort();

    runOp(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 1, 1);

    for (int i = 0; i < 20; i++) begin
      runOp($urandom, $urandom, 1'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
